// File: rtl/lbm_step_sequencer.sv
// lbm_step_sequencer: sweeps collide/stream/boundary phases over all lattice nodes for each LBM time step
module lbm_step_sequencer #(
  parameter int MAX_TIME = 8,
  parameter int NODES = 64,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
  parameter int NODE_WIDTH = $clog2(NODES)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Abort,
  input  logic                        Node_ready,
  output logic                        Node_valid,
  output logic [1:0]                  Phase,
  output logic [NODE_WIDTH-1:0]       Node_addr,
  output logic [TIME_COUNT_WIDTH-1:0] Time_step,
  output logic                        Step_tick,
  output logic                        Busy,
  output logic                        Done
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLIDE  = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_BOUNDARY = 3'd3;
  localparam logic [2:0] S_ADVANCE  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [NODE_WIDTH-1:0]       LAST_NODE = NODE_WIDTH'(NODES - 1);
  localparam logic [TIME_COUNT_WIDTH-1:0] LAST_STEP = TIME_COUNT_WIDTH'(MAX_TIME - 1);
  logic [2:0]                  state_q, state_d;
  logic [NODE_WIDTH-1:0]       addr_q, addr_d;
  logic [TIME_COUNT_WIDTH-1:0] ts_q, ts_d;
  logic                        xfer;
  // Moore outputs decoded from the current state
  always_comb begin
    Node_valid = state_q == S_COLLIDE || state_q == S_STREAM || state_q == S_BOUNDARY;
    Phase      = state_q == S_COLLIDE ? 2'b00 :
                 state_q == S_STREAM  ? 2'b01 :
                 state_q == S_BOUNDARY ? 2'b10 : 2'b11;
    Step_tick  = state_q == S_ADVANCE;
    Busy       = Node_valid || Step_tick;
    Done       = state_q == S_DONE;
    Node_addr  = addr_q;
    Time_step  = ts_q;
    xfer       = Node_valid && Node_ready;
  end
  // Next state: abort beats start, a node moves only on a transfer, ADVANCE is a single-cycle step boundary
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ts_d    = ts_q;
    if (Busy && Abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      ts_d    = '0;
    end else if ((state_q == S_IDLE || state_q == S_DONE) && Start) begin
      state_d = S_COLLIDE;
      addr_d  = '0;
      ts_d    = '0;
    end else if (xfer) begin
      addr_d  = addr_q == LAST_NODE ? '0 : addr_q + 1'b1;
      state_d = addr_q != LAST_NODE ? state_q :
                state_q == S_COLLIDE ? S_STREAM :
                state_q == S_STREAM ? S_BOUNDARY : S_ADVANCE;
    end else if (state_q == S_ADVANCE) begin
      state_d = ts_q == LAST_STEP ? S_DONE : S_COLLIDE;
      ts_d    = ts_q == LAST_STEP ? ts_q : ts_q + 1'b1;
    end else if (state_q > S_DONE) begin
      state_d = S_IDLE;
      addr_d  = '0;
      ts_d    = '0;
    end
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ts_q    <= ts_d;
    end
  end
endmodule

// File: tb/tb_lbm_step_sequencer.sv
// tb_lbm_step_sequencer: scoreboard bench comparing the sequencer against a position-counter reference model
module tb_lbm_step_sequencer;
  localparam int MT = 2;
  localparam int N  = 4;
  localparam int TW = $clog2(MT);
  localparam int NW = $clog2(N);
  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic          Node_ready = 1'b0;
  logic          Node_valid, Step_tick, Busy, Done;
  logic [1:0]    Phase;
  logic [NW-1:0] Node_addr;
  logic [TW-1:0] Time_step;
  typedef struct packed {
    logic          v;
    logic [1:0]    ph;
    logic [NW-1:0] a;
    logic [TW-1:0] t;
    logic          tk;
    logic          b;
    logic          d;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  bit stop = 0;
  int mode = 0;
  int pos = 0;
  int ts = 0;
  always #5 Clk = ~Clk;
  lbm_step_sequencer #(.MAX_TIME(MT), .NODES(N)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Node_ready(Node_ready),
    .Node_valid(Node_valid), .Phase(Phase), .Node_addr(Node_addr), .Time_step(Time_step),
    .Step_tick(Step_tick), .Busy(Busy), .Done(Done)
  );
  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask
  // mode 0 idle, 1 running, 2 done; pos counts completed transfers in the step, 3*N means step boundary
  task automatic model_push(bit r, bit s, bit a, bit rd);
    exp_t e;
    bit   run;
    if (!r) begin
      mode = 0; pos = 0; ts = 0;
    end else if (mode == 1 && a) begin
      mode = 0; pos = 0; ts = 0;
    end else if (mode != 1 && s) begin
      mode = 1; pos = 0; ts = 0;
    end else if (mode == 1) begin
      if (pos == 3 * N) begin
        pos = 0;
        if (ts == MT - 1) mode = 2;
        else ts++;
      end else if (rd) pos++;
    end
    run  = mode == 1 && pos < 3 * N;
    e.v  = run;
    e.ph = run ? 2'(pos / N) : 2'b11;
    e.a  = run ? NW'(pos % N) : '0;
    e.t  = TW'(ts);
    e.tk = mode == 1 && pos == 3 * N;
    e.b  = mode == 1;
    e.d  = mode == 2;
    sb.push_back(e);
  endtask
  task automatic drive(bit r, bit s, bit a, bit rd);
    Reset = r; Start = s; Abort = a; Node_ready = rd;
    model_push(r, s, a, rd);
    @(negedge Clk);
  endtask
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("node_valid", int'(Node_valid), int'(e.v));
      chk("phase", int'(Phase), int'(e.ph));
      chk("node_addr", int'(Node_addr), int'(e.a));
      chk("time_step", int'(Time_step), int'(e.t));
      chk("step_tick", int'(Step_tick), int'(e.tk));
      chk("busy", int'(Busy), int'(e.b));
      chk("done", int'(Done), int'(e.d));
    end else if (!stop) chk("scoreboard_underflow", 0, 1);
  end
  initial begin
    drive(0, 0, 0, 0);
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 1);
    drive(1, 1, 1, 1);
    drive(1, 1, 0, 1);
    for (int i = 0; i < 30; i++) drive(1, 0, 0, 1);
    drive(1, 0, 1, 1);
    drive(1, 1, 0, 1);
    for (int i = 0; i < 60; i++) drive(1, 0, 0, i % 2 == 0);
    drive(1, 1, 0, 1);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 1);
    drive(1, 0, 1, 1);
    drive(1, 1, 0, 1);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 1);
    drive(0, 1, 1, 1);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(99) != 0, $urandom_range(5) == 0, $urandom_range(49) == 0, $urandom_range(3) != 0);
    stop = 1;
    @(posedge Clk);
    #2;
    chk("scoreboard_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lbm_step_sequencer.md
LBM_STEP_SEQUENCER -- requirements
Module: lbm_step_sequencer

Interface
REQ-001 Parameter MAX_TIME, default 8: number of LBM time steps per run; legal range is 2 or more.
REQ-002 Parameter NODES, default 64: lattice nodes swept per phase; legal range is 2 or more.
REQ-003 Parameter TIME_COUNT_WIDTH, default $clog2(MAX_TIME): width of Time_step.
REQ-004 Parameter NODE_WIDTH, default $clog2(NODES): width of Node_addr.
REQ-005 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 Reset  input  1  synchronous, active-low reset, sampled on the Clk rising edge.
REQ-007 Start  input  1  run request; sampled only in IDLE or DONE.
REQ-008 Abort  input  1  synchronous abandon of the current run.
REQ-009 Node_ready  input  1  datapath accepts the current node.
REQ-010 Node_valid  output  1  the current Phase/Node_addr is offered to the datapath.
REQ-011 Phase  output  2  00 = collide, 01 = stream, 10 = boundary, 11 = unused/idle.
REQ-012 Node_addr  output  NODE_WIDTH  lattice node index being offered.
REQ-013 Time_step  output  TIME_COUNT_WIDTH  index of the time step in progress.
REQ-014 Step_tick  output  1  one-cycle pulse when a time step completes.
REQ-015 Busy  output  1  high in every state except IDLE and DONE.
REQ-016 Done  output  1  high in DONE.

Function
REQ-017 States SHALL be IDLE, COLLIDE, STREAM, BOUNDARY, ADVANCE and DONE.
REQ-018 IDLE, on Start=1: go to COLLIDE with Node_addr=0 and Time_step=0.
REQ-019 DONE, on Start=1: behave as REQ-018 and clear Done on the same edge.
REQ-020 Start SHALL be ignored while Busy=1.
REQ-021 Node_valid SHALL be 1 exactly in COLLIDE, STREAM and BOUNDARY.
REQ-022 Phase SHALL be 00/01/10 in COLLIDE/STREAM/BOUNDARY respectively and 11 in all other states.
REQ-023 Transfer SHALL be Node_valid & Node_ready in the same cycle; Phase and Node_addr SHALL hold stable until the transfer.
REQ-024 On a transfer with Node_addr < NODES-1, Node_addr SHALL increment by 1 and the state SHALL hold.
REQ-025 On a transfer with Node_addr = NODES-1, Node_addr SHALL wrap to 0 and the state SHALL advance COLLIDE->STREAM->BOUNDARY->ADVANCE.
REQ-026 A phase SHALL take at least NODES cycles; with Node_ready held at 1 it SHALL take exactly NODES cycles, with no bubble between phases.
REQ-027 ADVANCE SHALL last exactly one cycle with Step_tick=1 and Node_valid=0.
REQ-028 ADVANCE with Time_step < MAX_TIME-1: Time_step increments and the state goes to COLLIDE.
REQ-029 ADVANCE with Time_step = MAX_TIME-1: Time_step holds (no wrap) and the state goes to DONE.
REQ-030 With Node_ready held at 1, one time step SHALL take 3*NODES+1 cycles.
REQ-031 DONE SHALL hold Time_step=MAX_TIME-1, Done=1 and Busy=0 until Start or Reset.
REQ-032 Abort=1 in any Busy state: next edge goes to IDLE with Node_addr=0 and Time_step=0.
REQ-033 An Abort-triggered transfer SHALL not be counted.
REQ-034 No Step_tick SHALL be issued on the Abort edge.
REQ-035 Abort in IDLE or DONE SHALL have no effect.
REQ-036 Abort and Start together: Abort SHALL win.
REQ-037 Step_tick SHALL never be high in two consecutive cycles.
REQ-038 Node_addr SHALL never exceed NODES-1.
REQ-039 Time_step SHALL never exceed MAX_TIME-1.

Reset
REQ-040 Reset=0 at a Clk edge: state IDLE, Node_addr=0, Time_step=0, Phase=11, Node_valid=0, Step_tick=0, Busy=0, Done=0.
REQ-041 Reset SHALL override Start and Abort.
REQ-042 Reset asserted mid-phase SHALL discard the in-flight node with no Step_tick.
REQ-043 Reset SHALL have no asynchronous effect on any output.

Verification (NODES=4, MAX_TIME=2)
REQ-044 Reset, then Start pulse, Node_ready=1 throughout -> Node_addr 0,1,2,3 in each of Phase 00,01,10; Step_tick at cycle 13 and cycle 26 after Start; Time_step 0->1 only; Done=1 from cycle 27.
REQ-045 Node_ready toggling 1,0 -> each Node_addr held 2 cycles with Phase stable; first Step_tick at cycle 25.
REQ-046 Abort at STREAM, Node_addr=2, Node_ready=1 -> next cycle IDLE, Node_valid=0, Node_addr=0, Time_step=0, no Step_tick.
REQ-047 Start while Busy at COLLIDE, Node_addr=1 -> no state change; Start in DONE -> COLLIDE, Time_step=0, Done=0.
REQ-048 Reset=0 during BOUNDARY, Time_step=1 -> next edge all outputs at REQ-040 values; Start and Abort asserted with Reset -> still IDLE.
REQ-049 Start and Abort asserted together in IDLE -> remains IDLE; Start alone next cycle -> COLLIDE.
